ifm_unpacker: RTL and testbench
===============================

IFM_UNPACKER -- requirements
Module: ifm_unpacker

Interface
REQ-001 SHALL have parameter LANE_W, default 16, the lane value width in bits.
REQ-002 SHALL have parameter WORD_W, default 64, the stream word width in bits (fixed at 4*LANE_W).
REQ-003 SHALL have parameter LANES, default 13, the number of parallel output lanes.
REQ-004 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port is_mp  input  1  mode select: 1 = single-lane (maxpool) mode, 0 = 13-lane mode.
REQ-007 SHALL have port s_data  input  WORD_W  packed word; value 0 in bits [15:0], value 3 in bits [63:48].
REQ-008 SHALL have port s_valid  input  1  word valid.
REQ-009 SHALL have port s_last  input  1  marks the final word of a channel block.
REQ-010 SHALL have port s_ready  output  1  word accepted on the clock edge where s_valid && s_ready.
REQ-011 SHALL have port lane_data  output  LANES*LANE_W  lane k at bits [k*LANE_W +: LANE_W]; registered.
REQ-012 SHALL have port lane_valid  output  1  lane_data valid.
REQ-013 SHALL have port lane_last  output  1  final vector of a block.
REQ-014 SHALL have port lane_ready  input  1  consumer accepts lane_data when lane_valid && lane_ready.

Function
REQ-015 SHALL, in lane mode, keep a residue of c values (c in 0..12); an accepted word appends 4 values, oldest first.
REQ-016 SHALL, when c+4 >= 13, load lanes 0..12 with the 13 oldest values, set lane_valid on the same edge (latency 1 cycle from accept to visible output), and keep c+4-13 values as residue.
REQ-017 SHALL, on an accepted word with s_last and c+4 >= 13, emit the vector with lane_last=1, discard the remaining values, and set c to 0.
REQ-018 SHALL, on an accepted word with s_last and c+4 < 13, emit the c+4 values in lanes 0..c+3, with zero in the upper lanes and lane_last=1, and set c to 0.
REQ-019 SHALL drive s_ready = !lane_valid || lane_ready in lane mode, so that back-to-back vectors run at one per cycle.
REQ-020 SHALL hold lane_data, lane_valid and lane_last stable while lane_valid && !lane_ready.
REQ-021 SHALL, in mp mode, on accepting a word, present value 0 on lane 0 with lanes 1..12 = 0, then present values 1, 2, 3 on successive lane handshakes.
REQ-022 SHALL, in mp mode, drive s_ready only when no values of the current word remain unpresented and (!lane_valid || lane_ready); a new word is accepted on the handshake of value 3.
REQ-023 SHALL, in mp mode, assert lane_last only with value 3 of a word carrying s_last.
REQ-024 SHALL sample is_mp only when idle (c=0, no mp values pending, lane_valid=0); a change at any other time takes effect at the next idle point.
REQ-025 SHALL clear lane_valid on a handshake when no new vector is loaded on the same edge.

Reset
REQ-026 SHALL, while rst_n=0, force lane_data=0, lane_valid=0, lane_last=0, s_ready=0, c=0, mp state cleared and latched mode=lane; reset is asynchronous.
REQ-027 SHALL release to an idle state with s_ready=1 on the first clk edge after rst_n rises; a reset during a group discards all residue.

Configuration
REQ-028 SHALL, with macro IFM_UNPACKER_STATS_EN defined, add output vec_count [15:0], which counts lane handshakes, wraps at 65535->0, and is reset to 0.
REQ-029 SHALL, without IFM_UNPACKER_STATS_EN, have no vec_count port and no counter logic.

Structure
REQ-030 SHALL take LANE_W, WORD_W, LANES and the lane-index/residue-count typedefs from shared package ifm_pkg.
REQ-031 SHALL place mp-mode serialisation in sub-module ifm_mp_serializer (4-value shift register plus remaining count).

Verification
REQ-032 SHALL cover: lane mode, 13 words with word i carrying values 4i..4i+3, lane_ready=1 -> 4 vectors, vector j lane k = 13j+k, lane_valid visible after words 4, 7, 10, 13.
REQ-033 SHALL cover: 4 words with values 0..15, s_last on word 4 -> one vector with lanes = 0..12 and lane_last=1; values 13..15 dropped; the next word starts at lane 0.
REQ-034 SHALL cover: 2 words with values 0..7, s_last on word 2 -> lanes 0..7 = 0..7, lanes 8..12 = 0, lane_last=1.
REQ-035 SHALL cover: vector pending with lane_ready=0 for 5 cycles -> s_ready=0 and lane_data unchanged; lane_ready=1 -> handshake, then s_ready=1.
REQ-036 SHALL cover: mp mode, s_data=0x0004_0003_0002_0001, lane_ready=1 -> lane 0 shows 1, 2, 3, 4 on consecutive cycles with s_ready low for 3 cycles.
REQ-037 SHALL cover: rst_n pulsed low after 2 words of a group -> all outputs 0 at once; the next 4 words (values 0..15) yield a first vector with lanes 0..12 = 0..12.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared constants and types for the input-feature-map unpacker.
package ifm_pkg;
    localparam int IFM_LANE_W = 16;
    localparam int IFM_WORD_W = 4 * IFM_LANE_W;
    localparam int IFM_LANES  = 13;

    typedef logic [$clog2(IFM_LANES)-1:0] lane_idx_t;
    typedef logic [$clog2(IFM_LANES)-1:0] res_cnt_t;
endpackage

// File: rtl/ifm_mp_serializer.sv
// Maxpool-mode serializer: holds the unpresented values of one word and
// hands them out one per lane handshake, oldest first.
module ifm_mp_serializer
    import ifm_pkg::*;
#(
    parameter int LANE_W = IFM_LANE_W,
    parameter int WORD_W = IFM_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              last_i,
    output logic [LANE_W-1:0] val_o,
    output logic              last_o,
    output logic [1:0]        rem_o
);
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [1:0]        rem_q, rem_d;
    logic              last_q, last_d;

    // Value 0 leaves directly on load, so only values 1..3 are queued.
    always_comb begin
        sh_d   = sh_q;
        rem_d  = rem_q;
        last_d = last_q;
        if (load_i) begin
            sh_d   = data_i >> LANE_W;
            rem_d  = 2'd3;
            last_d = last_i;
        end else if (adv_i && (rem_q != 2'd0)) begin
            sh_d   = sh_q >> LANE_W;
            rem_d  = rem_q - 2'd1;
        end else begin
            sh_d   = sh_q;
        end
    end

    // Shift-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            rem_q  <= 2'd0;
            last_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            rem_q  <= rem_d;
            last_q <= last_d;
        end
    end

    assign val_o  = sh_q[LANE_W-1:0];
    assign last_o = last_q && (rem_q == 2'd1);
    assign rem_o  = rem_q;
endmodule

// File: rtl/ifm_unpacker.sv
// Unpacks 4-value stream words into 13-lane vectors, or into single-lane
// values in maxpool mode. Optional counter: define IFM_UNPACKER_STATS_EN.
module ifm_unpacker
    import ifm_pkg::*;
#(
    parameter int LANE_W = IFM_LANE_W,
    parameter int WORD_W = IFM_WORD_W,
    parameter int LANES  = IFM_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    is_mp,
    input  logic [WORD_W-1:0]       s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [LANES*LANE_W-1:0] lane_data,
    output logic                    lane_valid,
    output logic                    lane_last,
    input  logic                    lane_ready
`ifdef IFM_UNPACKER_STATS_EN
    ,
    output logic [15:0]             vec_count
`endif
);
    localparam int VEC_W  = LANES * LANE_W;
    localparam int RES_W  = (LANES - 1) * LANE_W;
    localparam int COMB_W = RES_W + WORD_W;
    localparam int CW     = $bits(res_cnt_t);

    logic              mode_q, run_q;
    res_cnt_t          c_q, c_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [VEC_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d;

    logic              idle_s, mode_s, hs_s, free_s, rdy_s;
    logic              acc_s, adv_s, load_s;
    logic [CW:0]       sum_s;
    logic [COMB_W-1:0] comb_s;
    logic [LANE_W-1:0] ser_val_s;
    logic              ser_last_s;
    logic [1:0]        ser_rem_s;

    // Mode is only re-sampled when nothing is buffered or on display.
    assign idle_s = (c_q == '0) && (ser_rem_s == 2'd0) && !valid_q;
    assign mode_s = idle_s ? is_mp : mode_q;
    assign hs_s   = valid_q && lane_ready;
    assign free_s = !valid_q || lane_ready;
    assign rdy_s  = run_q && (mode_s ? ((ser_rem_s == 2'd0) && free_s) : free_s);
    assign acc_s  = s_valid && rdy_s;
    assign load_s = acc_s && mode_s;
    assign adv_s  = hs_s && (ser_rem_s != 2'd0);

    // Residue bits above c are kept zero, so OR-ing the shifted word appends it.
    assign sum_s  = {1'b0, c_q} + (CW+1)'(4);
    assign comb_s = {{WORD_W{1'b0}}, res_q} | ({{RES_W{1'b0}}, s_data} << (c_q * LANE_W));

    ifm_mp_serializer #(
        .LANE_W (LANE_W),
        .WORD_W (WORD_W)
    ) u_mp_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .adv_i  (adv_s),
        .data_i (s_data),
        .last_i (s_last),
        .val_o  (ser_val_s),
        .last_o (ser_last_s),
        .rem_o  (ser_rem_s)
    );

    // Next output vector and residue.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q && !hs_s;
        last_d  = last_q && !hs_s;
        c_d     = c_q;
        res_d   = res_q;
        if (adv_s) begin
            data_d  = VEC_W'(ser_val_s);
            valid_d = 1'b1;
            last_d  = ser_last_s;
        end else if (load_s) begin
            data_d  = VEC_W'(s_data[LANE_W-1:0]);
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (acc_s) begin
            if (sum_s >= (CW+1)'(LANES)) begin
                data_d  = comb_s[VEC_W-1:0];
                valid_d = 1'b1;
                last_d  = s_last;
                if (s_last) begin
                    c_d   = '0;
                    res_d = '0;
                end else begin
                    c_d   = res_cnt_t'(sum_s - (CW+1)'(LANES));
                    res_d = RES_W'(comb_s >> VEC_W);
                end
            end else if (s_last) begin
                data_d  = comb_s[VEC_W-1:0];
                valid_d = 1'b1;
                last_d  = 1'b1;
                c_d     = '0;
                res_d   = '0;
            end else begin
                c_d   = res_cnt_t'(sum_s);
                res_d = comb_s[RES_W-1:0];
            end
        end else begin
            res_d = res_q;
        end
    end

    // Output and residue registers; run_q keeps s_ready low until after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            mode_q  <= 1'b0;
            c_q     <= '0;
            res_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            mode_q  <= mode_s;
            c_q     <= c_d;
            res_q   <= res_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign s_ready    = rdy_s;
    assign lane_data  = data_q;
    assign lane_valid = valid_q;
    assign lane_last  = last_q;

`ifdef IFM_UNPACKER_STATS_EN
    logic [15:0] vec_q;

    // Lane handshake counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= 16'd0;
        end else if (hs_s) begin
            vec_q <= vec_q + 16'd1;
        end else begin
            vec_q <= vec_q;
        end
    end

    assign vec_count = vec_q;
`else
    // Statistics disabled: no counter.
`endif
endmodule

// File: tb/tb_ifm_unpacker.sv
// Directed self-checking bench for ifm_unpacker.
module tb_ifm_unpacker;
    logic         clk;
    logic         rst_n;
    logic         is_mp;
    logic [63:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [207:0] lane_data;
    logic         lane_valid;
    logic         lane_last;
    logic         lane_ready;
`ifdef IFM_UNPACKER_STATS_EN
    logic [15:0]  vec_count;
`endif

    int checks = 0;
    int errors = 0;

    ifm_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .is_mp      (is_mp),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .lane_last  (lane_last),
        .lane_ready (lane_ready)
`ifdef IFM_UNPACKER_STATS_EN
        ,
        .vec_count  (vec_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mkw(input int b);
        return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
    endfunction

    function automatic logic [207:0] vec(input int base, input int n);
        logic [207:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k*16 +: 16] = 16'(base + k);
        return v;
    endfunction

    task automatic send(input logic [63:0] d, input logic l);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        #0;
        chk("s_ready_before_send", 208'(s_ready), 208'(1));
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; is_mp = 1'b0; s_data = '0; s_valid = 1'b0;
        s_last = 1'b0; lane_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_data", lane_data, 208'(0));
        chk("rst_valid", 208'(lane_valid), 208'(0));
        chk("rst_last", 208'(lane_last), 208'(0));
        chk("rst_s_ready", 208'(s_ready), 208'(0));
        #9 rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", 208'(s_ready), 208'(1));

        // 13 words -> 4 vectors after words 4, 7, 10, 13
        for (int i = 0; i < 13; i++) begin
            send(mkw(4 * i), 1'b0);
            if ((i + 1) == 4 || (i + 1) == 7 || (i + 1) == 10 || (i + 1) == 13) begin
                chk("stream_valid_hi", 208'(lane_valid), 208'(1));
                chk("stream_data", lane_data, vec(13 * (((i + 1) / 3) - 1), 13));
                chk("stream_last", 208'(lane_last), 208'(0));
            end else begin
                chk("stream_valid_lo", 208'(lane_valid), 208'(0));
            end
        end
        step();
        chk("drain_valid_clear", 208'(lane_valid), 208'(0));

        // s_last with overflow: values 13..15 dropped
        send(mkw(0), 1'b0); send(mkw(4), 1'b0); send(mkw(8), 1'b0);
        send(mkw(12), 1'b1);
        chk("last_full_data", lane_data, vec(0, 13));
        chk("last_full_valid", 208'(lane_valid), 208'(1));
        chk("last_full_last", 208'(lane_last), 208'(1));
        send(mkw(100), 1'b1);
        chk("restart_lane0_data", lane_data, vec(100, 4));
        chk("restart_lane0_last", 208'(lane_last), 208'(1));
        step();

        // short block: 8 values
        send(mkw(0), 1'b0); send(mkw(4), 1'b1);
        chk("short_data", lane_data, vec(0, 8));
        chk("short_last", 208'(lane_last), 208'(1));
        step();
        chk("short_clear", 208'(lane_valid), 208'(0));

        // backpressure for 5 cycles
        send(mkw(0), 1'b0); send(mkw(4), 1'b0); send(mkw(8), 1'b0); send(mkw(12), 1'b0);
        chk("bp_first_vec", lane_data, vec(0, 13));
        lane_ready = 1'b0;
        s_data = mkw(16); s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("bp_s_ready_low", 208'(s_ready), 208'(0));
            chk("bp_data_hold", lane_data, vec(0, 13));
            chk("bp_valid_hold", 208'(lane_valid), 208'(1));
            step();
        end
        lane_ready = 1'b1;
        #1;
        chk("bp_s_ready_release", 208'(s_ready), 208'(1));
        step();
        s_valid = 1'b0;
        chk("bp_after_valid", 208'(lane_valid), 208'(0));
        chk("bp_after_s_ready", 208'(s_ready), 208'(1));
        send(mkw(20), 1'b1);
        chk("bp_tail_data", lane_data, vec(13, 11));
        chk("bp_tail_last", 208'(lane_last), 208'(1));
        step();

        // maxpool mode
        is_mp = 1'b1;
        send(64'h0004_0003_0002_0001, 1'b0);
        chk("mp_v1", lane_data, 208'(1));
        chk("mp_v1_s_ready", 208'(s_ready), 208'(0));
        step();
        chk("mp_v2", lane_data, 208'(2));
        chk("mp_v2_s_ready", 208'(s_ready), 208'(0));
        step();
        chk("mp_v3", lane_data, 208'(3));
        chk("mp_v3_s_ready", 208'(s_ready), 208'(0));
        step();
        chk("mp_v4", lane_data, 208'(4));
        chk("mp_v4_s_ready", 208'(s_ready), 208'(1));
        chk("mp_v4_last", 208'(lane_last), 208'(0));
        send(mkw(5), 1'b1);
        chk("mp_b_v0", lane_data, 208'(5));
        chk("mp_b_v0_last", 208'(lane_last), 208'(0));
        step(); step(); step();
        chk("mp_b_v3", lane_data, 208'(8));
        chk("mp_b_v3_last", 208'(lane_last), 208'(1));
        step();
        chk("mp_idle_valid", 208'(lane_valid), 208'(0));
        is_mp = 1'b0;

        // reset in the middle of a group
        send(mkw(0), 1'b0); send(mkw(4), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", lane_data, 208'(0));
        chk("midrst_valid", 208'(lane_valid), 208'(0));
        chk("midrst_s_ready", 208'(s_ready), 208'(0));
        #2 rst_n = 1'b1;
        step();
        chk("midrst_release", 208'(s_ready), 208'(1));
        send(mkw(0), 1'b0); send(mkw(4), 1'b0); send(mkw(8), 1'b0); send(mkw(12), 1'b0);
        chk("midrst_vec", lane_data, vec(0, 13));
        chk("midrst_vec_valid", 208'(lane_valid), 208'(1));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
